sram_like_bridge: RTL

Parametrised memory-port bridge for the next-generation core. It converts the pipeline's valid/ready request channel into an SRAM-like bus (request/address_ok/data_ok) with up to MAX_OUTSTANDING requests in flight, and returns responses in order through a response buffer. It supports a cancel input (branch/exception flush) that silently discards all responses owed to already-issued requests. One instance sits on the instruction port and one on the data port, between the pipeline stages and the bus.

---
 rtl/sram_like_bridge_pkg.sv | 35 +++
 rtl/sram_like_bridge_if.sv | 47 ++++
 rtl/sram_like_bridge_checker.sv | 39 +++
 rtl/sram_like_bridge_fifo.sv | 77 +++++++
 rtl/sram_like_bridge.sv | 115 +++++++++++
 5 files changed

// File: rtl/sram_like_bridge_pkg.sv
// Shared types and sizing helpers for the SRAM-like memory-port bridge.
package cpu_bus_params;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_size_t;

  typedef struct packed {
    logic                                write;
    access_size_t                        size;
    logic [DEFAULT_DATA_WIDTH/8-1:0]     strobe;
    logic [DEFAULT_ADDRESS_WIDTH-1:0]    address;
    logic [DEFAULT_DATA_WIDTH-1:0]       write_data;
  } bus_request_data_t;

  typedef struct packed {
    logic                                write;
    logic [DEFAULT_DATA_WIDTH-1:0]       read_data;
  } bus_response_data_t;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pointer_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_like_bridge_if.sv
// Pipeline-side request/response channel, cancel, and SRAM-like bus signals.
interface sram_like_bridge_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                       cancel;
  logic                       request_valid;
  logic                       request_ready;
  logic                       request_write;
  logic [1:0]                 request_size;
  logic [DATA_WIDTH/8-1:0]    request_strobe;
  logic [ADDRESS_WIDTH-1:0]   request_address;
  logic [DATA_WIDTH-1:0]      request_write_data;
  logic                       response_valid;
  logic                       response_ready;
  logic                       response_write;
  logic [DATA_WIDTH-1:0]      response_read_data;
  logic                       bus_request;
  logic                       bus_write;
  logic [1:0]                 bus_size;
  logic [DATA_WIDTH/8-1:0]    bus_write_strobe;
  logic [ADDRESS_WIDTH-1:0]   bus_address;
  logic [DATA_WIDTH-1:0]      bus_write_data;
  logic                       bus_address_ok;
  logic                       bus_data_ok;
  logic [DATA_WIDTH-1:0]      bus_read_data;

  // Bridge view.
  modport slave (
    input  cancel, request_valid, request_write, request_size, request_strobe,
           request_address, request_write_data, response_ready,
           bus_address_ok, bus_data_ok, bus_read_data,
    output request_ready, response_valid, response_write, response_read_data,
           bus_request, bus_write, bus_size, bus_write_strobe, bus_address,
           bus_write_data
  );

  // Pipeline plus bus environment view.
  modport master (
    output cancel, request_valid, request_write, request_size, request_strobe,
           request_address, request_write_data, response_ready,
           bus_address_ok, bus_data_ok, bus_read_data,
    input  request_ready, response_valid, response_write, response_read_data,
           bus_request, bus_write, bus_size, bus_write_strobe, bus_address,
           bus_write_data
  );
endinterface

// File: rtl/sram_like_bridge_checker.sv
// Protocol and bookkeeping assertions for the bridge.
module sram_like_bridge_checker #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CW              = 2
) (
  input logic          clock,
  input logic          reset_,
  input logic          bus_data_ok,
  input logic          accept,
  input logic [CW-1:0] in_flight,
  input logic [CW-1:0] discard_pending,
  input logic [CW+1:0] total,
  input logic [CW-1:0] flag_count,
  input logic          flag_empty,
  input logic          flag_full,
  input logic          resp_push,
  input logic          resp_pop,
  input logic          resp_full
);

  a_data_ok_owed: assert property (@(posedge clock) disable iff (!reset_)
    bus_data_ok |-> (in_flight != '0) || (discard_pending != '0));

  a_total_bound: assert property (@(posedge clock) disable iff (!reset_)
    total <= (CW + 2)'(MAX_OUTSTANDING));

  a_flags_track: assert property (@(posedge clock) disable iff (!reset_)
    flag_count == in_flight);

  a_flag_avail: assert property (@(posedge clock) disable iff (!reset_)
    resp_push |-> !flag_empty);

  a_flag_room: assert property (@(posedge clock) disable iff (!reset_)
    accept |-> !flag_full);

  a_resp_room: assert property (@(posedge clock) disable iff (!reset_)
    resp_push |-> (!resp_full || resp_pop));

endmodule

// File: rtl/sram_like_bridge_fifo.sv
// In-order synchronous FIFO with flush; used for write flags and responses.
module sync_fifo
  import cpu_bus_params::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 2,
  localparam int CW    = count_width(DEPTH),
  localparam int PW    = pointer_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Gate requests so a push never overruns and a pop never underruns.
  always_comb begin
    empty     = (count_r == '0);
    full      = (count_r == CW'(DEPTH));
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= advance(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= advance(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Valid/ready to SRAM-like bus bridge with bounded outstanding requests,
// in-order response buffering and flush-by-discard on cancel.
module sram_like_bridge
  import cpu_bus_params::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                clock,
  input logic                reset_,
  sram_like_bridge_if.slave  port
);

  localparam int CW = count_width(MAX_OUTSTANDING);
  localparam int TW = CW + 2;
  localparam int RW = DATA_WIDTH + 1;

  logic [CW-1:0] in_flight_r;
  logic [CW-1:0] discard_pending_r;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] flag_count_s;
  logic [TW-1:0] total_s;
  logic          bus_request_s;
  logic          accept_s;
  logic          discard_s;
  logic          retire_s;
  logic          flag_head_s;
  logic          flag_empty_s;
  logic          flag_full_s;
  logic          resp_empty_s;
  logic          resp_full_s;
  logic [RW-1:0] resp_head_s;

  // Issue gating and classification of each returning beat.
  always_comb begin
    total_s       = TW'(in_flight_r) + TW'(discard_pending_r) + TW'(fifo_count_s);
    bus_request_s = reset_ & port.request_valid & ~port.cancel
                    & (total_s < TW'(MAX_OUTSTANDING));
    accept_s      = bus_request_s & port.bus_address_ok;
    discard_s     = reset_ & port.bus_data_ok & (discard_pending_r != '0);
    retire_s      = reset_ & port.bus_data_ok & (discard_pending_r == '0)
                    & (in_flight_r != '0);
  end

  assign port.bus_request        = bus_request_s;
  assign port.request_ready      = accept_s;
  assign port.bus_write          = port.request_write;
  assign port.bus_size           = port.request_size;
  assign port.bus_write_strobe   = (DATA_WIDTH/8)'(port.request_strobe);
  assign port.bus_address        = ADDRESS_WIDTH'(port.request_address);
  assign port.bus_write_data     = port.request_write_data;
  assign port.response_valid     = ~resp_empty_s;
  assign port.response_write     = resp_head_s[DATA_WIDTH];
  assign port.response_read_data = resp_head_s[DATA_WIDTH-1:0];

  // Outstanding counters; cancel turns everything still owed into discards.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      in_flight_r       <= '0;
      discard_pending_r <= '0;
    end else if (port.cancel) begin
      in_flight_r       <= '0;
      discard_pending_r <= discard_pending_r - CW'(discard_s)
                           + in_flight_r - CW'(retire_s);
    end else begin
      in_flight_r       <= in_flight_r + CW'(accept_s) - CW'(retire_s);
      discard_pending_r <= discard_pending_r - CW'(discard_s);
    end
  end

  sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_flag_fifo (
    .clock     (clock),
    .reset_    (reset_),
    .flush     (port.cancel),
    .push      (accept_s),
    .push_data (port.request_write),
    .pop       (retire_s),
    .pop_data  (flag_head_s),
    .count     (flag_count_s),
    .empty     (flag_empty_s),
    .full      (flag_full_s)
  );

  // Flush wins over a same-cycle push, so a beat retired during cancel is dropped.
  sync_fifo #(.WIDTH(RW), .DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
    .clock     (clock),
    .reset_    (reset_),
    .flush     (port.cancel),
    .push      (retire_s),
    .push_data ({flag_head_s, port.bus_read_data}),
    .pop       (port.response_ready),
    .pop_data  (resp_head_s),
    .count     (fifo_count_s),
    .empty     (resp_empty_s),
    .full      (resp_full_s)
  );

  sram_like_bridge_checker #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CW(CW)) u_checker (
    .clock           (clock),
    .reset_          (reset_),
    .bus_data_ok     (port.bus_data_ok),
    .accept          (accept_s),
    .in_flight       (in_flight_r),
    .discard_pending (discard_pending_r),
    .total           (total_s),
    .flag_count      (flag_count_s),
    .flag_empty      (flag_empty_s),
    .flag_full       (flag_full_s),
    .resp_push       (retire_s),
    .resp_pop        (port.response_ready & ~resp_empty_s),
    .resp_full       (resp_full_s)
  );

endmodule
